// File: rtl/rf_port_sched.sv
// Single-port register file arbiter: sequences rs1/rs2 reads for decode,
// interleaves writeback writes, and returns a consistent operand pair.
module rf_port_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [ADDR_W-1:0] dec_rs1_i,
    input  logic [ADDR_W-1:0] dec_rs2_i,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [DATA_W-1:0] op_rs1_data_o,
    output logic [DATA_W-1:0] op_rs2_data_o,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [ADDR_W-1:0] wb_reg_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              rf_write_en_o,
    output logic              rf_read_en_o,
    output logic [ADDR_W-1:0] rf_write_reg_o,
    output logic [ADDR_W-1:0] rf_read_reg_o,
    output logic [DATA_W-1:0] rf_write_data_o,
    input  logic [DATA_W-1:0] rf_read_data_i
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, OUT} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] rs1_q, rs2_q;
    logic              rd1_q;       // rs1 read was issued for this request
    logic              last_rd2_q;  // most recent read targeted rs2
    logic              read_en_q;
    logic [ADDR_W-1:0] read_reg_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic              op_valid_q;
    logic              wb_open;

    // The write port is free whenever no read is in flight on the shared port.
    assign wb_open = rst_n && ((state_q == IDLE) || (state_q == CAP) || (state_q == OUT));

    assign dec_ready_o     = rst_n && (state_q == IDLE);
    assign wb_ready_o      = wb_open && wb_valid_i;
    assign rf_write_en_o   = wb_ready_o && (wb_reg_i != '0);
    assign rf_write_reg_o  = wb_ready_o ? wb_reg_i : '0;
    assign rf_write_data_o = wb_ready_o ? wb_data_i : '0;
    assign rf_read_en_o    = read_en_q;
    assign rf_read_reg_o   = read_reg_q;
    assign op_valid_o      = op_valid_q;
    assign op_rs1_data_o   = op1_q;
    assign op_rs2_data_o   = op2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd1_q      <= 1'b0;
            last_rd2_q <= 1'b0;
            read_en_q  <= 1'b0;
            read_reg_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            op_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dec_valid_i) begin
                        rs1_q      <= dec_rs1_i;
                        rs2_q      <= dec_rs2_i;
                        op1_q      <= '0;
                        op2_q      <= '0;
                        rd1_q      <= 1'b0;
                        last_rd2_q <= 1'b0;
                        if (dec_rs1_i != '0) begin
                            state_q    <= RD1;
                            read_en_q  <= 1'b1;
                            read_reg_q <= dec_rs1_i;
                        end else if (dec_rs2_i != '0) begin
                            state_q    <= RD2;
                            read_en_q  <= 1'b1;
                            read_reg_q <= dec_rs2_i;
                        end else begin
                            state_q    <= OUT;
                            op_valid_q <= 1'b1;
                        end
                    end
                end
                RD1: begin
                    rd1_q <= 1'b1;
                    if ((rs2_q != '0) && (rs2_q != rs1_q)) begin
                        state_q    <= RD2;
                        read_reg_q <= rs2_q;
                    end else begin
                        state_q   <= CAP;
                        read_en_q <= 1'b0;
                    end
                end
                RD2: begin
                    // Data returning now belongs to the rs1 read issued in RD1.
                    if (rd1_q) begin
                        op1_q <= rf_read_data_i;
                    end
                    last_rd2_q <= 1'b1;
                    read_en_q  <= 1'b0;
                    state_q    <= CAP;
                end
                CAP: begin
                    if (last_rd2_q) begin
                        op2_q <= rf_read_data_i;
                    end else begin
                        op1_q <= rf_read_data_i;
                        if (rs2_q == rs1_q) begin
                            op2_q <= rf_read_data_i;
                        end
                    end
                    op_valid_q <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (op_ready_i) begin
                        op_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_port_sched.sv
// Self-checking bench for rf_port_sched: directed scenarios then random
// requests, checked against an architectural register shadow and latency rule.
module tb_rf_port_sched;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid, dec_ready, op_valid, op_ready;
    logic [AW-1:0] dec_rs1, dec_rs2, wb_reg, rf_write_reg, rf_read_reg;
    logic [DW-1:0] op_rs1_data, op_rs2_data, wb_data, rf_write_data;
    logic          wb_valid, wb_ready, rf_write_en, rf_read_en;
    logic [DW-1:0] rf_rdata = '0;
    logic [DW-1:0] mem[32] = '{default: '0};
    logic [DW-1:0] ref_regs[32] = '{default: '0};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_port_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
        .op_valid_o(op_valid), .op_ready_i(op_ready),
        .op_rs1_data_o(op_rs1_data), .op_rs2_data_o(op_rs2_data),
        .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
        .wb_reg_i(wb_reg), .wb_data_i(wb_data),
        .rf_write_en_o(rf_write_en), .rf_read_en_o(rf_read_en),
        .rf_write_reg_o(rf_write_reg), .rf_read_reg_o(rf_read_reg),
        .rf_write_data_o(rf_write_data), .rf_read_data_i(rf_rdata)
    );

    // Register file behind the port: registered read, never reset.
    always @(posedge clk) begin
        if (rf_write_en) mem[rf_write_reg] <= rf_write_data;
        if (rf_read_en) rf_rdata <= mem[rf_read_reg];
    end

    // Architectural state: every granted write to a nonzero register.
    always @(posedge clk) begin
        if (rst_n && wb_valid && wb_ready && (wb_reg != '0)) ref_regs[wb_reg] <= wb_data;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input logic open, input string tag);
        logic g;
        g = wb_valid & open;
        chk({tag, "_wb_ready"}, 32'(wb_ready), 32'(g));
        chk({tag, "_wr_en"}, 32'(rf_write_en), 32'(g & (wb_reg != '0)));
        if (g) begin
            chk({tag, "_wr_reg"}, 32'(rf_write_reg), 32'(wb_reg));
            chk({tag, "_wr_data"}, rf_write_data, wb_data);
        end
        chk({tag, "_excl"}, 32'(rf_write_en & rf_read_en), 32'd0);
    endtask

    // mode 0: no writes, 1: one write in the accept cycle,
    // 2: continuous write from the cycle after accept, 3: random writes.
    task automatic drive_wb(input int mode, input int k, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
        case (mode)
            0: wb_valid = 1'b0;
            1: begin wb_valid = (k == 0); wb_reg = wr; wb_data = wd; end
            2: begin wb_valid = (k >= 1); wb_reg = wr; wb_data = wd; end
            default: begin
                wb_valid = 1'($urandom_range(0, 1));
                wb_reg   = AW'($urandom_range(0, 7));
                wb_data  = $urandom;
            end
        endcase
    endtask

    task automatic do_write(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wb_valid = 1'b1; wb_reg = r; wb_data = d;
        #1;
        check_wb(1'b1, "write");
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
    endtask

    // Called at negedge+1 with the scheduler idle; returns at negedge+1 idle.
    task automatic do_req(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input int hold,
                          input int mode, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] o1, output logic [DW-1:0] o2);
        logic [DW-1:0] e1, e2;
        logic [AW-1:0] rl[2];
        int nrd, lat, k;
        nrd = 0;
        rl[0] = '0; rl[1] = '0;
        if (rs1 != '0) begin rl[nrd] = rs1; nrd++; end
        if ((rs2 != '0) && (rs2 != rs1)) begin rl[nrd] = rs2; nrd++; end
        lat = (nrd == 0) ? 1 : ((nrd == 1) ? 3 : 4);

        dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; op_ready = 1'b0;
        drive_wb(mode, 0, wr, wd);
        #1;
        chk("accept_dec_ready", 32'(dec_ready), 32'd1);
        check_wb(1'b1, "accept");
        k = 1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                dec_valid = 1'b0;
                // Expected operands: architectural state right after the accept edge.
                e1 = (rs1 == '0) ? '0 : ref_regs[rs1];
                e2 = (rs2 == '0) ? '0 : ref_regs[rs2];
            end
            dec_rs1 = AW'($urandom); dec_rs2 = AW'($urandom);
            drive_wb(mode, k, wr, wd);
            #1;
            chk("seq_rd_en", 32'(rf_read_en), 32'(c <= nrd));
            if (c <= nrd) chk("seq_rd_reg", 32'(rf_read_reg), 32'(rl[c-1]));
            chk("seq_op_valid", 32'(op_valid), 32'(c == lat));
            chk("seq_dec_ready", 32'(dec_ready), 32'd0);
            check_wb(c > nrd, "seq");
            k++;
        end
        o1 = op_rs1_data; o2 = op_rs2_data;
        chk("op_rs1", op_rs1_data, e1);
        chk("op_rs2", op_rs2_data, e2);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            op_ready = (h == hold);
            drive_wb(mode, k, wr, wd);
            #1;
            chk("hold_op_valid", 32'(op_valid), 32'd1);
            chk("hold_rs1", op_rs1_data, e1);
            chk("hold_rs2", op_rs2_data, e2);
            chk("hold_rd_en", 32'(rf_read_en), 32'd0);
            check_wb(1'b1, "hold");
            k++;
        end
        @(negedge clk);
        op_ready = 1'b0; wb_valid = 1'b0;
        #1;
        chk("done_op_valid", 32'(op_valid), 32'd0);
        chk("done_dec_ready", 32'(dec_ready), 32'd1);
        $display("req rs1=%0d rs2=%0d reads=%0d op1=%h op2=%h", rs1, rs2, nrd, o1, o2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dec_ready"}, 32'(dec_ready), 32'd0);
        chk({tag, "_op_valid"}, 32'(op_valid), 32'd0);
        chk({tag, "_op_rs1"}, op_rs1_data, 32'd0);
        chk({tag, "_op_rs2"}, op_rs2_data, 32'd0);
        chk({tag, "_wb_ready"}, 32'(wb_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(rf_write_en), 32'd0);
        chk({tag, "_rd_en"}, 32'(rf_read_en), 32'd0);
        chk({tag, "_wr_reg"}, 32'(rf_write_reg), 32'd0);
        chk({tag, "_rd_reg"}, 32'(rf_read_reg), 32'd0);
        chk({tag, "_wr_data"}, rf_write_data, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] o1, o2;
        rst_n = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dec_valid = 1'($urandom); dec_rs1 = AW'($urandom); dec_rs2 = AW'($urandom);
            op_ready = 1'($urandom); wb_valid = 1'($urandom); wb_reg = AW'($urandom);
            wb_data = $urandom;
            #1;
            check_all_zero("reset");
        end
        @(negedge clk);
        rst_n = 1'b1; dec_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        #1;
        chk("post_reset_dec_ready", 32'(dec_ready), 32'd1);

        do_write(5'd5, 32'h11);
        do_write(5'd6, 32'h22);
        do_write(5'd7, 32'hABCD);
        do_write(5'd9, 32'h77);
        do_write(5'd3, 32'h10);

        // Two reads, operands held three cycles
        do_req(5'd5, 5'd6, 3, 0, '0, '0, o1, o2);
        chk("two_read_rs1", o1, 32'h11);
        chk("two_read_rs2", o2, 32'h22);

        do_req(5'd0, 5'd0, 1, 0, '0, '0, o1, o2);
        chk("x0_pair", {o1[15:0], o2[15:0]}, 32'd0);

        do_req(5'd7, 5'd7, 0, 0, '0, '0, o1, o2);
        chk("dup_rs1", o1, 32'hABCD);
        chk("dup_rs2", o2, 32'hABCD);

        // Write held through the sequence is blocked during reads
        do_req(5'd9, 5'd5, 1, 2, 5'd9, 32'h55, o1, o2);
        chk("wb_during_rd_rs1", o1, 32'h77);
        chk("wb_during_rd_rs2", o2, 32'h11);
        do_req(5'd9, 5'd0, 0, 0, '0, '0, o1, o2);
        chk("wb_after_rd", o1, 32'h55);

        // Write in the accept cycle is seen by the request
        do_req(5'd3, 5'd0, 0, 1, 5'd3, 32'h99, o1, o2);
        chk("accept_cycle_wr", o1, 32'h99);

        do_write(5'd0, 32'hFF);
        do_req(5'd0, 5'd6, 0, 0, '0, '0, o1, o2);
        chk("x0_after_write_rs1", o1, 32'd0);
        chk("x0_after_write_rs2", o2, 32'h22);

        // Reset asserted while in RD2 aborts the request
        dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd6;
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_in_rd2", 32'(rf_read_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        #1;
        check_all_zero("abort_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("abort_no_op_valid", 32'(op_valid), 32'd0);
            chk("abort_idle", 32'(dec_ready), 32'd1);
            @(negedge clk);
        end
        #1;
        do_req(5'd5, 5'd6, 0, 0, '0, '0, o1, o2);
        chk("after_abort_rs1", o1, 32'h11);
        chk("after_abort_rs2", o2, 32'h22);

        // Random requests with random concurrent writeback traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) do_write(AW'($urandom_range(0, 7)), $urandom);
            do_req(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), 3, '0, '0, o1, o2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
